mag_cmp_seq: RTL and testbench

Parametrised sequential magnitude comparator: compares two W-bit operands one D-bit digit per clock, most-significant digit first. It terminates early on the first differing digit and reports equal, greater-than or less-than. Operands may be unsigned or two's-complement. It is the multi-cycle, wide-operand successor to the combinational 2-bit equality comparator, and sits on a start/done handshake for use by datapath controllers where a full-width single-cycle compare is too costly.

---
 rtl/mag_cmp_pkg.sv | 10 +
 rtl/mag_cmp_seq_digit_cmp.sv | 12 +
 rtl/mag_cmp_seq.sv | 118 +++++++++++
 tb/tb_mag_cmp_seq.sv | 122 ++++++++++++
 4 files changed

// File: rtl/mag_cmp_pkg.sv
// Shared types and result encodings for the sequential magnitude comparator.
package mag_cmp_pkg;
  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  // Result encoding as {aeqb, agtb, altb}
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_EQ   = 3'b100;
  localparam logic [2:0] RES_GT   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;
endpackage

// File: rtl/mag_cmp_seq_digit_cmp.sv
// Combinational D-bit unsigned digit comparator.
module digit_cmp #(
  parameter int D = 4
) (
  input  logic [D-1:0] x,
  input  logic [D-1:0] y,
  output logic         eq,
  output logic         gt
);
  assign eq = (x == y);
  assign gt = (x > y);
endmodule

// File: rtl/mag_cmp_seq.sv
// Sequential MSD-first magnitude comparator with early exit and start/done handshake.
module mag_cmp_seq
  import mag_cmp_pkg::*;
#(
  parameter int W = 16,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         done_tick,
  output logic         aeqb,
  output logic         agtb,
  output logic         altb
);
  localparam int N  = W / D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST     = CW'(N - 1);
  localparam logic [D-1:0]  MSB_MASK = D'(1) << (D - 1);

  if ((D < 1) || (W % D != 0)) begin : g_bad_params
    $error("mag_cmp_seq: W must be a positive multiple of D");
  end

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic           mode_q, mode_d;
  logic [CW-1:0]  i_q, i_d;
  logic           aeqb_q, aeqb_d, agtb_q, agtb_d, altb_q, altb_d;

  logic [D-1:0]   dig_a, dig_b, flip;
  logic           dig_eq, dig_gt;

  // Signed compare only needs the sign bit of the top digit inverted
  assign flip  = (mode_q && (i_q == '0)) ? MSB_MASK : '0;
  assign dig_a = a_q[W-1 -: D] ^ flip;
  assign dig_b = b_q[W-1 -: D] ^ flip;

  digit_cmp #(.D(D)) u_digit_cmp (
    .x  (dig_a),
    .y  (dig_b),
    .eq (dig_eq),
    .gt (dig_gt)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    i_d     = i_q;
    aeqb_d  = aeqb_q;
    agtb_d  = agtb_q;
    altb_d  = altb_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          mode_d  = signed_mode;
          i_d     = '0;
          state_d = CMP;
        end
      end
      CMP: begin
        if (!dig_eq) begin
          aeqb_d  = 1'b0;
          agtb_d  = dig_gt;
          altb_d  = ~dig_gt;
          state_d = DONE;
        end else if (i_q == LAST) begin
          aeqb_d  = 1'b1;
          agtb_d  = 1'b0;
          altb_d  = 1'b0;
          state_d = DONE;
        end else begin
          a_d = a_q << D;
          b_d = b_q << D;
          i_d = i_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      i_q     <= '0;
      aeqb_q  <= 1'b0;
      agtb_q  <= 1'b0;
      altb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      i_q     <= i_d;
      aeqb_q  <= aeqb_d;
      agtb_q  <= agtb_d;
      altb_q  <= altb_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign done_tick = (state_q == DONE);
  assign aeqb      = aeqb_q;
  assign agtb      = agtb_q;
  assign altb      = altb_q;
endmodule

// File: tb/tb_mag_cmp_seq.sv
// Directed bench for mag_cmp_seq at W=16, D=4.
module tb_mag_cmp_seq;
  import mag_cmp_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, signed_mode;
  logic [15:0] a, b;
  logic        ready, done_tick, aeqb, agtb, altb;
  int          checks = 0;
  int          passed = 0;

  mag_cmp_seq #(.W(16), .D(4)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .ready(ready), .done_tick(done_tick),
    .aeqb(aeqb), .agtb(agtb), .altb(altb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Waits (from the negedge after the start edge) for done_tick; returns start-to-done cycles.
  task automatic wait_done(output int cnt);
    cnt = 1;
    while (cnt < 20) begin
      @(negedge clk);
      if (done_tick) break;
      cnt++;
    end
  endtask

  task automatic run_cmp(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic sm, input logic [2:0] er, input int el, input bit poke);
    int cnt;
    @(negedge clk);
    chk({tag, "_ready"}, ready, 1);
    a = av; b = bv; signed_mode = sm; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = 16'(~av); b = 16'(~bv); signed_mode = ~sm;
    cnt = 1;
    while (cnt < 20) begin
      @(negedge clk);
      if (done_tick) break;
      if (poke && cnt == 1) begin
        start = 1'b1; a = 16'hFFFF; b = 16'h0000;
      end else start = 1'b0;
      cnt++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, cnt, el);
    chk({tag, "_flags"}, {aeqb, agtb, altb}, er);
    @(negedge clk);
    chk({tag, "_pulse"}, done_tick, 0);
    chk({tag, "_rdy_after"}, ready, 1);
    chk({tag, "_hold"}, {aeqb, agtb, altb}, er);
  endtask

  initial begin
    int cnt;
    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_done", done_tick, 0);
    chk("rst_flags", {aeqb, agtb, altb}, RES_NONE);
    reset = 1'b0;

    run_cmp("equal",   16'h1234, 16'h1234, 1'b0, RES_EQ, 5, 1'b0);
    run_cmp("early",   16'h8000, 16'h7FFF, 1'b0, RES_GT, 2, 1'b0);
    run_cmp("sgn_lt",  16'h8000, 16'h7FFF, 1'b1, RES_LT, 2, 1'b0);
    run_cmp("sgn_gt",  16'hFFFF, 16'hFFFE, 1'b1, RES_GT, 5, 1'b0);
    run_cmp("mid",     16'h12E0, 16'h12F0, 1'b0, RES_LT, 4, 1'b0);
    run_cmp("busy",    16'h1234, 16'h1234, 1'b0, RES_EQ, 5, 1'b1);

    // Reset while comparing digit 2
    @(negedge clk);
    a = 16'h1111; b = 16'h1111; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_ready", ready, 1);
    chk("mrst_flags", {aeqb, agtb, altb}, RES_NONE);
    chk("mrst_done", done_tick, 0);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("mrst_nodone", done_tick, 0);
    end

    // Back-to-back with start held high
    @(negedge clk);
    a = 16'h0001; b = 16'h0002; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 a = 16'h0003; b = 16'h0003;
    wait_done(cnt);
    chk("b2b1_lat", cnt, 5);
    chk("b2b1_flags", {aeqb, agtb, altb}, RES_LT);
    @(negedge clk);
    chk("b2b1_pulse", done_tick, 0);
    chk("b2b1_ready", ready, 1);
    @(posedge clk);
    wait_done(cnt);
    start = 1'b0;
    chk("b2b2_lat", cnt, 5);
    chk("b2b2_flags", {aeqb, agtb, altb}, RES_EQ);
    @(negedge clk);
    chk("b2b2_pulse", done_tick, 0);
    chk("b2b2_ready", ready, 1);
    @(negedge clk);
    chk("b2b_idle", ready, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
